// File: rtl/fnd_pkg.sv
// ----------------------------------------------------------------------------
// fnd_pkg
// Constants shared by the display-side font decoder and the receive-side scan
// decoder: the active-low 7-segment fonts, the special codes returned for dot,
// blank and unknown fonts, and the observable states of the scan decoder.
// ----------------------------------------------------------------------------
package fnd_pkg;

    // Active-low segment fonts, bit 7 = dot.
    localparam logic [7:0] FONT_0     = 8'hc0;
    localparam logic [7:0] FONT_1     = 8'hf9;
    localparam logic [7:0] FONT_2     = 8'ha4;
    localparam logic [7:0] FONT_3     = 8'hb0;
    localparam logic [7:0] FONT_4     = 8'h99;
    localparam logic [7:0] FONT_5     = 8'h92;
    localparam logic [7:0] FONT_6     = 8'h82;
    localparam logic [7:0] FONT_7     = 8'hf8;
    localparam logic [7:0] FONT_8     = 8'h80;
    localparam logic [7:0] FONT_9     = 8'h90;
    localparam logic [7:0] FONT_DOT   = 8'h7f;
    localparam logic [7:0] FONT_BLANK = 8'hff;

    // Codes for fonts that are not decimal digits.
    localparam logic [3:0] CODE_DOT   = 4'ha;
    localparam logic [3:0] CODE_BAD   = 4'he;
    localparam logic [3:0] CODE_BLANK = 4'hf;

    // Observable dwell state of the scan decoder.
    typedef enum logic [1:0] {
        SCAN_IDLE     = 2'd0,  // sampled select invalid
        SCAN_SETTLING = 2'd1,  // valid select, dwell not yet accepted
        SCAN_HELD     = 2'd2   // dwell accepted, waiting for it to end
    } scan_state_e;

endpackage

// File: rtl/fnd_font_encoder.sv
// ----------------------------------------------------------------------------
// fnd_font_encoder
// Purely combinational conversion of an active-low 7-segment font back to the
// 4-bit code that produced it.
//   i_font  [7:0]  active-low segment font, bit 7 = dot
//   o_code  [3:0]  decoded code (0-9, CODE_DOT, CODE_BLANK, or CODE_BAD)
//   o_bad          high when the font is not one of the known patterns
// ----------------------------------------------------------------------------
module fnd_font_encoder
    import fnd_pkg::*;
(
    input  logic [7:0] i_font,
    output logic [3:0] o_code,
    output logic       o_bad
);

    always_comb begin
        o_code = CODE_BAD;
        o_bad  = 1'b0;
        case (i_font)
            FONT_0:     o_code = 4'h0;
            FONT_1:     o_code = 4'h1;
            FONT_2:     o_code = 4'h2;
            FONT_3:     o_code = 4'h3;
            FONT_4:     o_code = 4'h4;
            FONT_5:     o_code = 4'h5;
            FONT_6:     o_code = 4'h6;
            FONT_7:     o_code = 4'h7;
            FONT_8:     o_code = 4'h8;
            FONT_9:     o_code = 4'h9;
            FONT_DOT:   o_code = CODE_DOT;
            FONT_BLANK: o_code = CODE_BLANK;
            default: begin
                o_code = CODE_BAD;
                o_bad  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// ----------------------------------------------------------------------------
// fnd_scan_decoder
// Monitors the multiplexed FND bus, debounces each digit dwell, decodes the
// font and reassembles a full frame once every position has been captured.
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_fnd_digit [DIGITS]    active-low digit select (exactly one low = valid)
//   i_fnd_font  [8]         active-low segment font
//   o_value     [4*DIGITS]  last complete frame, position k at [4k+3:4k]
//   o_valid                 one-cycle pulse when o_value updates
//   o_err                   OR of the frame's unknown-font flags
//   o_digit_err [DIGITS]    per-position unknown-font flags of the frame
//   o_dbg_state             current dwell state (idle / settling / held)
// Handshake: o_valid is a pulse with no back-pressure; o_value, o_err and
// o_digit_err are stable from the o_valid cycle until the next o_valid.
// ----------------------------------------------------------------------------
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DIGITS-1:0]     i_fnd_digit,
    input  logic [7:0]            i_fnd_font,
    output logic [4*DIGITS-1:0]   o_value,
    output logic                  o_valid,
    output logic                  o_err,
    output logic [DIGITS-1:0]     o_digit_err,
    output scan_state_e           o_dbg_state
);

    localparam int              CNT_W   = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    // Sample registers and dwell tracking
    logic [DIGITS-1:0]   digit_q, digit_d;
    logic [7:0]          font_q, font_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                captured_q, captured_d;

    // Frame assembly
    logic [4*DIGITS-1:0] buf_q, buf_d;
    logic [DIGITS-1:0]   ebuf_q, ebuf_d;
    logic [DIGITS-1:0]   mask_q, mask_d;

    // Outputs
    logic [4*DIGITS-1:0] value_q, value_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [DIGITS-1:0]   derr_q, derr_d;

    logic [3:0]          enc_code;
    logic                enc_bad;
    logic [DIGITS-1:0]   sel_onehot;
    logic                sel_valid;
    logic                same_pair;
    logic [DIGITS-1:0]   q_onehot;
    logic                q_valid;
    scan_state_e         state_w;

    // The captured font is the one on the inputs at the capturing edge; it is
    // identical to the previous sample whenever the counter has reached max.
    fnd_font_encoder u_enc (
        .i_font (i_fnd_font),
        .o_code (enc_code),
        .o_bad  (enc_bad)
    );

    always_comb begin
        digit_d    = i_fnd_digit;
        font_d     = i_fnd_font;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        buf_d      = buf_q;
        ebuf_d     = ebuf_q;
        mask_d     = mask_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        err_d      = err_q;
        derr_d     = derr_q;

        // Exactly one low select bit: nonzero and a power of two once inverted.
        sel_onehot = ~i_fnd_digit;
        sel_valid  = (sel_onehot != '0) &&
                     ((sel_onehot & (sel_onehot - DIGITS'(1))) == '0);
        same_pair  = (i_fnd_digit == digit_q) && (i_fnd_font == font_q);

        if (!sel_valid) begin
            cnt_d      = '0;
            captured_d = 1'b0;
        end else if (same_pair) begin
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            // A new pair starts a new dwell, even if it is a glitch recovery.
            cnt_d      = CNT_W'(1);
            captured_d = 1'b0;
        end

        if (sel_valid && (cnt_d == CNT_MAX) && !captured_d) begin
            captured_d = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                if (sel_onehot[k]) begin
                    buf_d[4*k +: 4] = enc_code;
                    ebuf_d[k]       = enc_bad;
                end
            end
            mask_d = mask_q | sel_onehot;
            if (&mask_d) begin
                value_d = buf_d;
                derr_d  = ebuf_d;
                err_d   = |ebuf_d;
                valid_d = 1'b1;
                mask_d  = '0;
            end
        end
    end

    // Debug view of the dwell state, derived from the registered sample.
    always_comb begin
        q_onehot = ~digit_q;
        q_valid  = (q_onehot != '0) &&
                   ((q_onehot & (q_onehot - DIGITS'(1))) == '0);
        if (!q_valid) begin
            state_w = SCAN_IDLE;
        end else if (captured_q) begin
            state_w = SCAN_HELD;
        end else begin
            state_w = SCAN_SETTLING;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            digit_q    <= '0;
            font_q     <= '0;
            cnt_q      <= '0;
            captured_q <= 1'b0;
            buf_q      <= '0;
            ebuf_q     <= '0;
            mask_q     <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            derr_q     <= '0;
        end else begin
            digit_q    <= digit_d;
            font_q     <= font_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            buf_q      <= buf_d;
            ebuf_q     <= ebuf_d;
            mask_q     <= mask_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            derr_q     <= derr_d;
        end
    end

    assign o_value     = value_q;
    assign o_valid     = valid_q;
    assign o_err       = err_q;
    assign o_digit_err = derr_q;
    assign o_dbg_state = state_w;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_fnd_scan_decoder
// Directed scans of the FND bus with hand-computed frame values.
// ----------------------------------------------------------------------------
module tb_fnd_scan_decoder;
    import fnd_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fnd_digit;
    logic [7:0]  fnd_font;
    logic [15:0] value;
    logic        valid;
    logic        err;
    logic [3:0]  digit_err;
    scan_state_e dbg_state;

    always #5 clk = ~clk;

    fnd_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_fnd_digit (fnd_digit),
        .i_fnd_font  (fnd_font),
        .o_value     (value),
        .o_valid     (valid),
        .o_err       (err),
        .o_digit_err (digit_err),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;

    // o_valid changes on the rising edge; count pulses on the falling edge.
    always @(negedge clk) begin
        if (!rst && valid) valid_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic dwell_raw(input logic [3:0] sel, input logic [7:0] font, input int n);
        @(negedge clk);
        fnd_digit = sel;
        fnd_font  = font;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dwell(input int pos, input logic [7:0] font, input int n);
        logic [3:0] one;
        one = 4'b0001;
        dwell_raw(~(one << pos), font, n);
    endtask

    task automatic idle(input int n);
        dwell_raw(4'b1111, FONT_BLANK, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fnd_digit = 4'b1111;
        fnd_font  = FONT_BLANK;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int base;

    initial begin
        rst = 1'b1;
        fnd_digit = 4'b1111;
        fnd_font  = FONT_BLANK;
        do_reset();
        check("reset_value", 32'(value), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_digit_err", 32'(digit_err), 32'h0);

        // Frame 4321 with latency check on the final digit.
        base = valid_cnt;
        dwell(0, FONT_1, 8);
        dwell(1, FONT_2, 8);
        dwell(2, FONT_3, 8);
        check("no_valid_partial", 32'(valid_cnt - base), 32'd0);
        @(negedge clk);
        fnd_digit = 4'b0111;
        fnd_font  = FONT_4;
        repeat (3) @(posedge clk);
        #1;
        check("valid_before_latency", 32'(valid), 32'h0);
        @(posedge clk);
        #1;
        check("valid_at_latency", 32'(valid), 32'h1);
        check("value_4321_early", 32'(value), 32'h4321);
        @(posedge clk);
        #1;
        check("valid_one_cycle", 32'(valid), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        idle(2);
        check("pulses_4321", 32'(valid_cnt - base), 32'd1);
        check("value_4321", 32'(value), 32'h4321);
        check("err_4321", 32'(err), 32'h0);
        check("digit_err_4321", 32'(digit_err), 32'h0);

        // Dot and blank fonts.
        base = valid_cnt;
        dwell(0, FONT_0, 8);
        dwell(1, FONT_0, 8);
        dwell(2, FONT_DOT, 8);
        dwell(3, FONT_BLANK, 8);
        idle(2);
        check("pulses_fa00", 32'(valid_cnt - base), 32'd1);
        check("value_fa00", 32'(value), 32'hfa00);
        check("err_fa00", 32'(err), 32'h0);

        // Unknown font on position 1.
        base = valid_cnt;
        dwell(0, FONT_0, 8);
        dwell(1, 8'h55, 8);
        dwell(2, FONT_0, 8);
        dwell(3, FONT_0, 8);
        idle(2);
        check("pulses_bad", 32'(valid_cnt - base), 32'd1);
        check("value_bad", 32'(value), 32'h00e0);
        check("digit_err_bad", 32'(digit_err), 32'b0010);
        check("err_bad", 32'(err), 32'h1);

        // Short dwell on position 0 is ignored; a 4-cycle dwell completes it.
        base = valid_cnt;
        dwell(0, FONT_9, 3);
        dwell(1, FONT_1, 8);
        dwell(2, FONT_2, 8);
        dwell(3, FONT_3, 8);
        idle(2);
        check("short_dwell_no_frame", 32'(valid_cnt - base), 32'd0);
        check("short_dwell_value_kept", 32'(value), 32'h00e0);
        dwell(0, FONT_5, 4);
        idle(2);
        check("min_dwell_frame", 32'(valid_cnt - base), 32'd1);
        check("value_3215", 32'(value), 32'h3215);
        check("err_cleared", 32'(err), 32'h0);
        check("digit_err_cleared", 32'(digit_err), 32'h0);

        // Glitched dwell: no run reaches 4 samples, so no capture.
        base = valid_cnt;
        dwell(1, FONT_6, 8);
        dwell(2, FONT_6, 8);
        dwell(3, FONT_6, 8);
        dwell(0, FONT_1, 2);
        dwell(0, FONT_BLANK, 1);
        dwell(0, FONT_1, 3);
        idle(2);
        check("glitch_no_frame", 32'(valid_cnt - base), 32'd0);
        dwell(0, FONT_1, 4);
        idle(2);
        check("glitch_recovered", 32'(valid_cnt - base), 32'd1);
        check("value_6661", 32'(value), 32'h6661);

        // Invalid selects between dwells, long final dwell.
        base = valid_cnt;
        dwell(0, FONT_7, 8);
        dwell_raw(4'b1010, FONT_8, 6);
        dwell(1, FONT_8, 8);
        dwell_raw(4'b1111, FONT_8, 6);
        dwell_raw(4'b0000, FONT_8, 6);
        dwell(2, FONT_9, 8);
        dwell(3, FONT_4, 20);
        idle(2);
        check("long_dwell_one_pulse", 32'(valid_cnt - base), 32'd1);
        check("value_4987", 32'(value), 32'h4987);

        // Reset after three captures discards the partial frame.
        base = valid_cnt;
        dwell(0, FONT_6, 8);
        dwell(1, FONT_6, 8);
        dwell(2, FONT_6, 8);
        do_reset();
        check("rst_value", 32'(value), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_digit_err", 32'(digit_err), 32'h0);
        dwell(3, FONT_3, 8);
        dwell(0, FONT_1, 8);
        dwell(1, FONT_2, 8);
        idle(2);
        check("rst_partial_dropped", 32'(valid_cnt - base), 32'd0);
        check("rst_value_held", 32'(value), 32'h0);
        dwell(2, FONT_4, 8);
        idle(2);
        check("rst_full_frame", 32'(valid_cnt - base), 32'd1);
        check("value_3421", 32'(value), 32'h3421);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
